// File: rtl/rr_arbiter_n_if.sv
// Request/grant bundle for rr_arbiter_n. The master drives requests and the slave (arbiter) returns
// the grant, the owner index, busy and the preemption pulse.
interface rr_arbiter_n_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           preempt;

  modport master (output req, input gnt, gnt_id, busy, preempt);
  modport slave  (input req, output gnt, gnt_id, busy, preempt);
endinterface

// File: rtl/rr_arbiter_n.sv
// N-requester round-robin arbiter with grant-hold and zero-gap handoff.
// Optional ARB_HOLD_LIMIT_EN: revoke a grant after MAX_HOLD cycles when another requester waits.
module rr_arbiter_n #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input logic         clk,
  input logic         rst,
  rr_arbiter_n_if.slave bus
);
  localparam int IDW = $clog2(N);

  if (N < 2 || N > 32 || MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_param_check
    $error("rr_arbiter_n: N must be 2..32 and MAX_HOLD must be 1..65535");
  end

  typedef enum logic {IDLE, OWNED} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [N-1:0]   cand;
  logic [IDW:0]   pick;
  logic           found;
  logic [IDW-1:0] win;
  logic [IDW-1:0] win_next;
  logic [N-1:0]   win_onehot;
  logic           owner_done;
  logic           limit_hit;
  logic           take;
  logic           drop;

  // The first set bit of cand at or after start, wrapping at N. Bit IDW of the result flags a hit.
  function automatic logic [IDW:0] pick_next(input logic [N-1:0] c, input logic [IDW-1:0] start);
    logic [IDW:0] result;
    int           idx;
    result = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      if (c[idx]) result = {1'b1, IDW'(idx)};
    end
    return result;
  endfunction

  // While owned, ptr already equals owner+1, so one search from ptr serves both the idle case and the handoff case.
  always_comb begin
    cand = (state == OWNED) ? (bus.req & ~bus.gnt) : bus.req;
    pick = pick_next(cand, ptr);
  end

  assign found      = pick[IDW];
  assign win        = pick[IDW-1:0];
  assign win_next   = (win == IDW'(N - 1)) ? '0 : win + 1'b1;
  assign win_onehot = N'(1) << win;
  assign owner_done = (state == OWNED) && !bus.req[bus.gnt_id];

`ifdef ARB_HOLD_LIMIT_EN
  logic [15:0] hold_cnt;

  // hold_cnt counts completed owned cycles, so the limit bites on the MAX_HOLD-th grant cycle.
  assign limit_hit = (int'(hold_cnt) + 1) >= MAX_HOLD;
`else
  assign limit_hit   = 1'b0;
  assign bus.preempt = 1'b0;
`endif

  assign take = (state == IDLE) ? found : (found && (owner_done || limit_hit));
  assign drop = owner_done && !found;

  // NOTE: every register here uses <= so all of them sample the pre-edge values of state, ptr and req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      bus.gnt    <= '0;
      bus.gnt_id <= '0;
      bus.busy   <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt    <= '0;
      bus.preempt <= 1'b0;
`endif
    end else begin
      if (take) begin
        state      <= OWNED;
        ptr        <= win_next;
        bus.gnt    <= win_onehot;
        bus.gnt_id <= win;
        bus.busy   <= 1'b1;
      end else if (drop) begin
        state      <= IDLE;
        bus.gnt    <= '0;
        bus.gnt_id <= '0;
        bus.busy   <= 1'b0;
      end
`ifdef ARB_HOLD_LIMIT_EN
      bus.preempt <= take && (state == OWNED) && !owner_done;
      if (take) hold_cnt <= '0;
      else if (state == OWNED && int'(hold_cnt) < MAX_HOLD) hold_cnt <= hold_cnt + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n: an N=4 instance (MAX_HOLD=4) and an N=3 instance share clk/rst.
// The hold-limit steps expect preemption only when ARB_HOLD_LIMIT_EN is defined.
`timescale 1ns/1ps
module tb_rr_arbiter_n;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rr_arbiter_n_if #(.N(4)) bus4 ();
  rr_arbiter_n_if #(.N(3)) bus3 ();

  rr_arbiter_n #(.N(4), .MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  rr_arbiter_n #(.N(3))               dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic [3:0] g, input logic [1:0] id, input logic b);
    check({tag, ".gnt"}, 32'(bus4.gnt), 32'(g));
    check({tag, ".gnt_id"}, 32'(bus4.gnt_id), 32'(id));
    check({tag, ".busy"}, 32'(bus4.busy), 32'(b));
  endtask

  logic [3:0] fair_req [5] = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [1:0] fair_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [2:0] n3_req   [4] = '{3'b111, 3'b110, 3'b101, 3'b011};
  logic [1:0] n3_id    [4] = '{2'd0, 2'd1, 2'd2, 2'd0};

  initial begin
    rst       = 1'b1;
    bus4.req  = '0;
    bus3.req  = '0;
    tick();
    tick();
    check4("reset", 4'b0000, 2'd0, 1'b0);
    check("reset.preempt", 32'(bus4.preempt), 32'd0);
    check("reset.n3_busy", 32'(bus3.busy), 32'd0);
    rst = 1'b0;

    // Asynchronous reset in the middle of a grant
    bus4.req = 4'b0110;
    tick();
    check4("first_grant", 4'b0010, 2'd1, 1'b1);
    tick();
    check4("hold_grant", 4'b0010, 2'd1, 1'b1);
    rst = 1'b1;
    #1;
    check4("async_reset", 4'b0000, 2'd0, 1'b0);
    #1;
    rst = 1'b0;
    tick();
    check4("after_reset", 4'b0010, 2'd1, 1'b1);
    bus4.req = 4'b0000;
    tick();
    check4("release_idle", 4'b0000, 2'd0, 1'b0);

    // Single requester held for five cycles
    bus4.req = 4'b0100;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check4($sformatf("single_c%0d", c), 4'b0100, 2'd2, 1'b1);
    end
    bus4.req = 4'b0000;
    tick();
    check4("single_release", 4'b0000, 2'd0, 1'b0);

    // Fairness starts from index 0 after a reset pulse
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus4.req = fair_req[i];
      tick();
      check4($sformatf("fair_%0d", i), 4'b0001 << fair_id[i], fair_id[i], 1'b1);
    end

    // Handoff skips idle requesters
    bus4.req = 4'b0010;
    tick();
    check4("skip_owner1", 4'b0010, 2'd1, 1'b1);
    bus4.req = 4'b1001;
    tick();
    check4("skip_to_3", 4'b1000, 2'd3, 1'b1);
    bus4.req = 4'b0001;
    tick();
    check4("wrap_to_0", 4'b0001, 2'd0, 1'b1);

    // Lone owner dropping and re-raising its request sees a one-cycle gap
    bus4.req = 4'b0000;
    tick();
    check4("gap_drop", 4'b0000, 2'd0, 1'b0);
    bus4.req = 4'b0001;
    tick();
    check4("gap_regrant", 4'b0001, 2'd0, 1'b1);
    bus4.req = 4'b0000;
    tick();
    check4("gap_idle", 4'b0000, 2'd0, 1'b0);

    // Hold limit: req0 held, req2 joins in grant cycle 2
    bus4.req = 4'b0001;
    tick();
    check4("hold_c1", 4'b0001, 2'd0, 1'b1);
    tick();
    bus4.req = 4'b0101;
    tick();
    check4("hold_c3", 4'b0001, 2'd0, 1'b1);
    tick();
    check4("hold_c4", 4'b0001, 2'd0, 1'b1);
    check("hold_c4.preempt", 32'(bus4.preempt), 32'd0);
    tick();
`ifdef ARB_HOLD_LIMIT_EN
    check4("hold_c5", 4'b0100, 2'd2, 1'b1);
    check("hold_c5.preempt", 32'(bus4.preempt), 32'd1);
    tick();
    check("hold_c6.preempt", 32'(bus4.preempt), 32'd0);
    check4("hold_c6", 4'b0100, 2'd2, 1'b1);
`else
    for (int c = 5; c <= 20; c++) begin
      check4($sformatf("nolimit_c%0d", c), 4'b0001, 2'd0, 1'b1);
      check($sformatf("nolimit_c%0d.preempt", c), 32'(bus4.preempt), 32'd0);
      tick();
    end
`endif
    bus4.req = 4'b0000;
    tick();
    check4("hold_idle", 4'b0000, 2'd0, 1'b0);

    // Non-power-of-two: N=3 wraps at 3
    for (int i = 0; i < 4; i++) begin
      bus3.req = n3_req[i];
      tick();
      check($sformatf("n3_%0d.gnt_id", i), 32'(bus3.gnt_id), 32'(n3_id[i]));
      check($sformatf("n3_%0d.gnt", i), 32'(bus3.gnt), 32'(3'b001 << n3_id[i]));
      check($sformatf("n3_%0d.in_range", i), 32'(bus3.gnt_id < 2'd3), 32'd1);
    end
    bus3.req = 3'b000;
    tick();
    check("n3_idle.busy", 32'(bus3.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
